// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and helpers for the UART TX frame arbiter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } arbState_t;

    // Width of a counter that must hold 0..maxVal; never narrower than one bit.
    function automatic int cntWidth(input int maxVal);
        int w;
        w = $clog2(maxVal + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or above ptr, wrapping
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    logic [PW:0] cand;
    logic        found;

    // Walk the requesters starting at ptr; the first active one wins.
    always_comb begin
        any   = |req;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) begin
                cand = cand - (PW+1)'(N);
            end
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                idx   = cand[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-level round-robin arbiter sharing one UART byte transmitter
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int NUM_REQ       = 2,
    parameter  int GAP_CYCLES    = 234,
    parameter  int STALL_TIMEOUT = 270000,
    localparam int IDW           = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 abort
);

    localparam int GW = cntWidth(GAP_CYCLES);
    localparam int SW = cntWidth(STALL_TIMEOUT);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);
    localparam logic [GW-1:0]  GAP_END   = GW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0]  STALL_END = SW'(STALL_TIMEOUT - 1);

    arbState_t      state;
    arbState_t      nextState;
    logic [IDW-1:0] rrPtr;
    logic [IDW-1:0] pickIdx;
    logic [IDW-1:0] nextId;
    logic           pickAny;
    logic [SW-1:0]  stallCnt;
    logic [GW-1:0]  gapCnt;
    logic           grantValid;
    logic           grantLast;
    logic           frameDone;
    logic           stallHit;
    logic           leaveXfer;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (IDW)
    ) uPick (
        .req (req_valid),
        .ptr (rrPtr),
        .any (pickAny),
        .idx (pickIdx)
    );

    assign grantValid = req_valid[grant_id];
    assign grantLast  = req_last[grant_id];
    assign frameDone  = grantValid & tx_ready & grantLast;
    // A source with valid high is never stalled, even when the UART holds off.
    assign stallHit   = (STALL_TIMEOUT != 0) && !grantValid && (stallCnt == STALL_END);
    assign leaveXfer  = (state == XFER) && (frameDone || stallHit);
    assign nextId     = (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode: grant on any request, leave a frame on last byte or timeout.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (pickAny) nextState = XFER;
            XFER: if (frameDone || stallHit) nextState = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (gapCnt == GAP_END) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Grant, rotation pointer, stall/gap counters and the registered abort pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr    <= '0;
            grant_id <= '0;
            stallCnt <= '0;
            gapCnt   <= '0;
            abort    <= 1'b0;
        end else begin
            abort <= (state == XFER) && stallHit;
            if (state == IDLE && pickAny) begin
                grant_id <= pickIdx;
            end
            if (leaveXfer) begin
                rrPtr <= nextId;
            end
            if (STALL_TIMEOUT != 0 && state == XFER && !leaveXfer && !grantValid) begin
                stallCnt <= stallCnt + SW'(1);
            end else begin
                stallCnt <= '0;
            end
            if (state == GAP && gapCnt != GAP_END) begin
                gapCnt <= gapCnt + GW'(1);
            end else begin
                gapCnt <= '0;
            end
        end
    end

    // Byte pass-through from the granted requester; everything quiet outside XFER.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        if (state == XFER) begin
            tx_valid = grantValid;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (IDW'(i) == grant_id) begin
                    tx_data      = req_data[i*8 +: 8];
                    req_ready[i] = tx_ready;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0][1:0]  reqValid;
    logic [1:0][15:0] reqData;
    logic [1:0][1:0]  reqLast;
    logic [1:0][1:0]  reqReady;
    logic [1:0]       txValid;
    logic [1:0][7:0]  txData;
    logic [1:0]       txReady;
    logic [1:0][0:0]  grantId;
    logic [1:0]       busy;
    logic [1:0]       abortS;

    logic [8:0] srcQ [4][$];
    logic [8:0] expQ [2][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hsCount [2];
    int lastHsCyc [2];
    int prevHsCyc [2];
    int busyFallCyc [2];
    int abortCount [2];
    int abortCyc [2];

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(4), .STALL_TIMEOUT(10)) dutA (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[0]), .req_data(reqData[0]), .req_last(reqLast[0]), .req_ready(reqReady[0]),
        .tx_valid(txValid[0]), .tx_data(txData[0]), .tx_ready(txReady[0]),
        .grant_id(grantId[0]), .busy(busy[0]), .abort(abortS[0])
    );

    uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(0), .STALL_TIMEOUT(0)) dutB (
        .clk(clk), .rst_n(rst_n),
        .req_valid(reqValid[1]), .req_data(reqData[1]), .req_last(reqLast[1]), .req_ready(reqReady[1]),
        .tx_valid(txValid[1]), .tx_data(txData[1]), .tx_ready(txReady[1]),
        .grant_id(grantId[1]), .busy(busy[1]), .abort(abortS[1])
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, expv);
        end
    endtask

    task automatic stepCyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pushByte(input int d, input int r, input logic [7:0] data, input logic last);
        srcQ[d*2 + r].push_back({last, data});
        expQ[d].push_back({1'(r), data});
    endtask

    task automatic waitHs(input int d, input int budget);
        int start;
        int n;
        start = hsCount[d];
        n = 0;
        while (hsCount[d] == start && n < budget) begin
            stepCyc(1);
            n++;
        end
        checkVal("wait_hs", (hsCount[d] != start) ? 1 : 0, 1);
    endtask

    task automatic waitDrain(input int d, input int budget);
        int n;
        n = 0;
        while ((expQ[d].size() != 0 || busy[d]) && n < budget) begin
            stepCyc(1);
            n++;
        end
        checkVal("drain_q", expQ[d].size(), 0);
        checkVal("drain_busy", 32'(busy[d]), 0);
    endtask

    task automatic doReset(input int n);
        for (int k = 0; k < 4; k++) srcQ[k].delete();
        for (int d = 0; d < 2; d++) expQ[d].delete();
        rst_n = 1'b0;
        stepCyc(n);
        rst_n = 1'b1;
    endtask

    // Source model: present queue heads, pop on a handshake seen before the edge.
    initial begin
        logic [3:0] take;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) take[k] = reqValid[k/2][k%2] && reqReady[k/2][k%2];
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (take[k] && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
                if (srcQ[k].size() > 0) begin
                    reqValid[k/2][k%2]           = 1'b1;
                    reqData[k/2][(k%2)*8 +: 8]   = srcQ[k][0][7:0];
                    reqLast[k/2][k%2]            = srcQ[k][0][8];
                end else begin
                    reqValid[k/2][k%2]           = 1'b0;
                    reqData[k/2][(k%2)*8 +: 8]   = 8'h00;
                    reqLast[k/2][k%2]            = 1'b0;
                end
            end
        end
    end

    // Monitor: score every transmitted byte, track timing of handshakes, aborts and busy.
    initial begin
        logic [8:0] expE;
        logic [1:0] prevBusy;
        prevBusy = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst_n && txValid[d] && txReady[d]) begin
                    prevHsCyc[d] = lastHsCyc[d];
                    lastHsCyc[d] = cyc;
                    hsCount[d]++;
                    if (expQ[d].size() == 0) begin
                        checkVal("sb_extra", expQ[d].size(), 1);
                    end else begin
                        expE = expQ[d].pop_front();
                        checkVal("sb_data", 32'(txData[d]), 32'(expE[7:0]));
                        checkVal("sb_grant", 32'(grantId[d]), 32'(expE[8]));
                    end
                end
                if (abortS[d]) begin
                    abortCount[d]++;
                    abortCyc[d] = cyc;
                end
                if (prevBusy[d] && !busy[d]) busyFallCyc[d] = cyc;
                prevBusy[d] = busy[d];
            end
        end
    end

    initial begin
        int hsC;
        int bad;
        int n;
        for (int d = 0; d < 2; d++) begin
            hsCount[d] = 0; lastHsCyc[d] = 0; prevHsCyc[d] = 0;
            busyFallCyc[d] = 0; abortCount[d] = 0; abortCyc[d] = 0;
        end
        rst_n    = 1'b0;
        txReady  = 2'b11;
        reqValid = '0;
        reqData  = '0;
        reqLast  = '0;
        stepCyc(3);

        checkVal("rst_busy", 32'(busy[0]), 0);
        checkVal("rst_tx_valid", 32'(txValid[0]), 0);
        checkVal("rst_tx_data", 32'(txData[0]), 0);
        checkVal("rst_req_ready", 32'(reqReady[0]), 0);
        checkVal("rst_grant", 32'(grantId[0]), 0);
        checkVal("rst_abort", 32'(abortS[0]), 0);
        checkVal("rst_rr_ptr", 32'(dutA.rrPtr), 0);
        rst_n = 1'b1;
        stepCyc(2);

        // Single requester, two-byte frame.
        pushByte(0, 0, 8'h48, 1'b0);
        pushByte(0, 0, 8'h69, 1'b1);
        waitDrain(0, 100);
        checkVal("t1_consecutive", lastHsCyc[0] - prevHsCyc[0], 1);
        checkVal("t1_gap_len", busyFallCyc[0] - lastHsCyc[0], 5);
        checkVal("t1_rr_ptr", 32'(dutA.rrPtr), 1);

        // Tie from reset, then a second tie shows rotation.
        doReset(2);
        pushByte(0, 0, 8'h10, 1'b0);
        pushByte(0, 0, 8'h11, 1'b1);
        pushByte(0, 1, 8'h20, 1'b0);
        pushByte(0, 1, 8'h21, 1'b1);
        waitDrain(0, 100);
        pushByte(0, 0, 8'h30, 1'b1);
        pushByte(0, 1, 8'h40, 1'b1);
        waitDrain(0, 100);
        checkVal("t2_rr_ptr", 32'(dutA.rrPtr), 0);

        // Long backpressure mid-frame must not abort.
        abortCount[0] = 0;
        pushByte(0, 0, 8'hA1, 1'b0);
        pushByte(0, 0, 8'hA2, 1'b1);
        waitHs(0, 50);
        @(posedge clk);
        #1;
        txReady[0] = 1'b0;
        bad = 0;
        repeat (500) begin
            stepCyc(1);
            if (!(txValid[0] && txData[0] == 8'hA2 && reqReady[0] == 2'b00)) bad++;
        end
        checkVal("t3_held", bad, 0);
        checkVal("t3_no_abort", abortCount[0], 0);
        checkVal("t3_busy", 32'(busy[0]), 1);
        txReady[0] = 1'b1;
        waitDrain(0, 50);

        // Stall: req1 sends one byte and goes quiet; req0 waits its turn.
        abortCount[0] = 0;
        pushByte(0, 1, 8'h5A, 1'b0);
        waitHs(0, 50);
        hsC = lastHsCyc[0];
        pushByte(0, 0, 8'hC3, 1'b1);
        waitDrain(0, 100);
        checkVal("t4_abort_count", abortCount[0], 1);
        checkVal("t4_abort_delay", abortCyc[0] - hsC, 11);

        // Reset in the middle of a frame granted to req1.
        txReady[0] = 1'b0;
        pushByte(0, 1, 8'h01, 1'b0);
        pushByte(0, 1, 8'h02, 1'b0);
        pushByte(0, 1, 8'h03, 1'b1);
        n = 0;
        while (!(busy[0] && grantId[0] == 1'b1) && n < 50) begin
            stepCyc(1);
            n++;
        end
        checkVal("t5_granted", 32'(grantId[0]), 1);
        srcQ[1].delete();
        expQ[0].delete();
        rst_n = 1'b0;
        stepCyc(1);
        checkVal("t5_busy", 32'(busy[0]), 0);
        checkVal("t5_tx_valid", 32'(txValid[0]), 0);
        checkVal("t5_tx_data", 32'(txData[0]), 0);
        checkVal("t5_req_ready", 32'(reqReady[0]), 0);
        checkVal("t5_grant", 32'(grantId[0]), 0);
        checkVal("t5_abort", 32'(abortS[0]), 0);
        rst_n = 1'b1;
        txReady[0] = 1'b1;
        stepCyc(3);
        checkVal("t5_stays_idle", 32'(busy[0]), 0);

        // No gap: back-to-back frames separated by exactly one IDLE cycle.
        pushByte(1, 0, 8'h81, 1'b1);
        pushByte(1, 0, 8'h82, 1'b1);
        waitDrain(1, 50);
        checkVal("t6_idle_cycle", lastHsCyc[1] - prevHsCyc[1], 2);
        checkVal("t6_no_abort", abortCount[1], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
